// File: rtl/non_restoring_divider_pkg.sv
// Shared constants and FSM encoding for the non-restoring divider.
package non_restoring_divider_pkg;

  localparam int DIV_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_e;

endpackage

// File: rtl/non_restoring_divider_if.sv
// Request/result bundle between an ALU sequencer (master) and the divider (slave).
interface non_restoring_divider_if #(
  parameter int BITS = 32
);
  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/non_restoring_divider_arith.sv
// Arithmetic leaf cells for the divider: a ripple-carry adder and a two's-complement negator.
module ripple_carry_adder #(
  parameter int BITS = 33
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            c_in_i,
  output logic [BITS-1:0] sum_o
);
  logic [BITS-1:0] carry;

  assign carry[0] = c_in_i;

  generate
    for (genvar gi = 0; gi < BITS; gi++) begin : g_fa
      assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ carry[gi];
      // The carry out of the top bit is never needed by the divider.
      if (gi < BITS - 1) begin : g_carry
        assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
      end
    end
  endgenerate
endmodule

module signed_compliment #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] in_i,
  output logic [BITS-1:0] out_o
);
  assign out_o = ~in_i + 1'b1;
endmodule

// File: rtl/non_restoring_divider.sv
// Signed 32-bit non-restoring divider, one quotient bit per clock; quotient truncates toward zero.
module non_restoring_divider
  import non_restoring_divider_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input logic                    clk,
  input logic                    reset_n,
  non_restoring_divider_if.slave bus
);
  localparam int CNT_W = $clog2(BITS) + 1;

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BITS:0]    a_q;
  logic [BITS-1:0]  q_q;
  logic [BITS-1:0]  d_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [BITS-1:0]  quot_q;
  logic [BITS-1:0]  rem_q;

  logic [BITS-1:0]  dvd_neg, dvs_neg, dvd_mag, dvs_mag;
  logic [BITS:0]    a_shift, add_a, add_b, d_ext, add_sum;
  logic             sub_op;
  logic [BITS-1:0]  q_neg, r_neg, r_mag, quot_d, rem_d;

  signed_compliment #(.BITS(BITS)) u_neg_dvd (.in_i(bus.dividend), .out_o(dvd_neg));
  signed_compliment #(.BITS(BITS)) u_neg_dvs (.in_i(bus.divisor),  .out_o(dvs_neg));

  assign dvd_mag = bus.dividend[BITS-1] ? dvd_neg : bus.dividend;
  assign dvs_mag = bus.divisor[BITS-1]  ? dvs_neg : bus.divisor;

  // The shift never changes A's sign (|A| < D <= 2^(BITS-1)), so the pre-shift sign picks the op.
  assign a_shift = {a_q[BITS-1:0], q_q[BITS-1]};
  assign sub_op  = (state_q == RUN) && !a_q[BITS];
  assign add_a   = (state_q == RUN) ? a_shift : a_q;
  assign d_ext   = {1'b0, d_q};
  assign add_b   = sub_op ? ~d_ext : d_ext;

  ripple_carry_adder #(.BITS(BITS+1)) u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .c_in_i (sub_op),
    .sum_o  (add_sum)
  );

  // In FIX the adder holds A + D, used only when the final remainder went negative.
  assign r_mag = a_q[BITS] ? add_sum[BITS-1:0] : a_q[BITS-1:0];

  signed_compliment #(.BITS(BITS)) u_neg_q (.in_i(q_q),   .out_o(q_neg));
  signed_compliment #(.BITS(BITS)) u_neg_r (.in_i(r_mag), .out_o(r_neg));

  assign quot_d = sign_q_q ? q_neg : q_q;
  assign rem_d  = sign_r_q ? r_neg : r_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q_q <= bus.dividend[BITS-1] ^ bus.divisor[BITS-1];
            sign_r_q <= bus.dividend[BITS-1];
            a_q      <= '0;
            d_q      <= dvs_mag;
            cnt_q    <= CNT_W'(BITS);
            busy_q   <= 1'b1;
            if (bus.divisor == '0) begin
              // Q carries the raw dividend through to become the remainder.
              q_q     <= bus.dividend;
              state_q <= ZERO;
            end else begin
              q_q     <= dvd_mag;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          a_q   <= add_sum;
          q_q   <= {q_q[BITS-2:0], ~add_sum[BITS]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= quot_d;
          rem_q   <= rem_d;
          dbz_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ZERO: begin
          quot_q  <= '1;
          rem_q   <= q_q;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_non_restoring_divider.sv
// Directed and back-to-back random checks of the divider against queued expected results.
module tb_non_restoring_divider;
  import non_restoring_divider_pkg::*;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  non_restoring_divider_if #(.BITS(DIV_BITS)) bus ();

  non_restoring_divider #(.BITS(DIV_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dbz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0)                                     return mk(32'hFFFF_FFFF, a, 1'b1);
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mk(32'h8000_0000, 32'd0, 1'b0);
    else                                                return mk(sa / sbv, sa % sbv, 1'b0);
  endfunction

  // Drives one request; returns at the falling edge of the done cycle so the next call is back-to-back.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int exp_lat, input int poke_at);
    exp_t got;
    int   cycles;
    int   busy_cnt;
    bit   done_seen;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    cycles    = 0;
    busy_cnt  = 0;
    done_seen = 1'b0;
    while (!done_seen && cycles < 200) begin
      @(negedge clk);
      if (bus.done) begin
        done_seen = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        cycles++;
        if (cycles == poke_at) begin
          bus.start    = 1'b1;
          bus.dividend = 32'd1;
          bus.divisor  = 32'd1;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check({tag, "_done"}, 32'(done_seen), 32'd1);
    check({tag, "_lat"}, cycles, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    got.q   = bus.quotient;
    got.r   = bus.remainder;
    got.dbz = bus.div_by_zero;
    e = sb.pop_front();
    check({tag, "_quot"}, got.q, e.q);
    check({tag, "_rem"}, got.r, e.r);
    check({tag, "_dbz"}, 32'(got.dbz), 32'(e.dbz));
    $display("DIV %s a=0x%08h b=0x%08h q=0x%08h r=0x%08h dbz=%0b lat=%0d",
             tag, a, b, got.q, got.r, got.dbz, cycles);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_quot"}, bus.quotient, 32'd0);
    check({tag, "_rem"}, bus.remainder, 32'd0);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          done_cnt;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_div("p100_p7",   32'd100,      32'd7,        mk(32'd14,        32'd2,        1'b0), 33, 0);
    run_div("n100_p7",   -32'sd100,    32'd7,        mk(-32'sd14,      -32'sd2,      1'b0), 33, 0);
    run_div("p100_n7",   32'd100,      -32'sd7,      mk(-32'sd14,      32'd2,        1'b0), 33, 0);
    run_div("n100_n7",   -32'sd100,    -32'sd7,      mk(32'd14,        -32'sd2,      1'b0), 33, 0);
    run_div("min_n1",    32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0,      1'b0), 33, 0);
    run_div("min_p1",    32'h8000_0000, 32'd1,       mk(32'h8000_0000, 32'd0,        1'b0), 33, 0);
    run_div("min_p3",    32'h8000_0000, 32'd3,       mk(32'hD555_5556, 32'hFFFF_FFFE, 1'b0), 33, 0);
    run_div("max_min",   32'h7FFF_FFFF, 32'h8000_0000, mk(32'd0,       32'h7FFF_FFFF, 1'b0), 33, 0);
    run_div("zero_p5",   32'd0,        32'd5,        mk(32'd0,         32'd0,        1'b0), 33, 0);
    run_div("p5_div0",   32'd5,        32'd0,        mk(32'hFFFF_FFFF, 32'd5,        1'b1),  1, 0);
    run_div("n9_div0",   -32'sd9,      32'd0,        mk(32'hFFFF_FFFF, -32'sd9,      1'b1),  1, 0);
    run_div("p7_p7",     32'd7,        32'd7,        mk(32'd1,         32'd0,        1'b0), 33, 0);

    // Abort mid-run: previous results are non-zero, so the reset clearing them is observable.
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    run_div("p50_p3_poke", 32'd50, 32'd3, mk(32'd16, 32'd2, 1'b0), 33, 10);

    for (int i = 0; i < 1000; i++) begin
      ra = $random;
      rb = $random;
      run_div($sformatf("rnd%0d", i), ra, rb, model(ra, rb), (rb == 32'd0) ? 1 : 33, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
